hmmm_controller: RTL and testbench

- Multicycle control FSM for the 4-bit HMMM-style processor.
- Fetches 10-bit instructions over a ready handshake and holds them in an internal instruction register (IR).
- Decodes each instruction and drives the PC register, register file, ALU and write-back mux of the datapath.
- Sits beside the datapath under the top level. Idles after reset so the program can be loaded, then runs until HALT.

---
 rtl/hmmm_controller.sv | 165 ++++++++++++++++
 tb/tb_hmmm_controller.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hmmm_controller.sv
// hmmm_controller: multicycle control FSM for the 4-bit HMMM-style processor.
// Fetches a 10-bit instruction into IR, decodes it, then drives the
// datapath strobes (PC, register file, ALU, write-back mux) for one cycle.
module hmmm_controller #(
    parameter int PC_WIDTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    input  logic [9:0]          instr,
    input  logic                imem_ready,
    input  logic [PC_WIDTH-1:0] pc,
    input  logic                rd1_zero,
    output logic                imem_req,
    output logic                pc_en,
    output logic                pc_load,
    output logic [PC_WIDTH-1:0] jump_target,
    output logic [1:0]          ra1,
    output logic [1:0]          ra2,
    output logic [1:0]          wa3,
    output logic                we3,
    output logic                wd_sel,
    output logic [3:0]          imm,
    output logic                alu_sub,
    output logic                halted,
    output logic                illegal
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_HALT   = 3'd4;

    localparam logic [3:0] OP_NOP   = 4'b0000;
    localparam logic [3:0] OP_HALT  = 4'b0001;
    localparam logic [3:0] OP_SETN  = 4'b0010;
    localparam logic [3:0] OP_ADD   = 4'b0011;
    localparam logic [3:0] OP_SUB   = 4'b0100;
    localparam logic [3:0] OP_JUMPN = 4'b0101;
    localparam logic [3:0] OP_JEQZN = 4'b0110;
    localparam logic [3:0] OP_JNEZN = 4'b0111;

    logic [2:0]          state;
    logic [2:0]          state_next;
    logic [9:0]          ir;
    logic [3:0]          op;
    logic                illegal_q;
    logic [PC_WIDTH-1:0] target_q;

    assign op = ir[9:6];

    // The PC was already incremented during FETCH, so the branch base is pc-1.
    // The 4-bit offset is signed; the sum wraps modulo 2^PC_WIDTH.
    function automatic logic [PC_WIDTH-1:0] branch_target(
        input logic [PC_WIDTH-1:0] pc_now,
        input logic [3:0]          offset
    );
        logic signed [PC_WIDTH-1:0] offset_ext;
        offset_ext = {{(PC_WIDTH-4){offset[3]}}, offset};
        return pc_now - PC_WIDTH'(1) + $unsigned(offset_ext);
    endfunction

    // Register-file addressing comes straight from IR; conditional branches
    // read the tested register rX through port 1.
    always_comb begin
        ra1 = ir[3:2];
        if (op == OP_JEQZN || op == OP_JNEZN)
            ra1 = ir[5:4];
    end

    assign ra2         = ir[1:0];
    assign wa3         = ir[5:4];
    assign imm         = ir[3:0];
    assign jump_target = target_q;
    assign illegal     = illegal_q;
    assign halted      = (state == S_HALT);

    // Next-state logic for the fetch/decode/execute sequence.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (run) state_next = S_FETCH;
            S_FETCH:  if (imem_ready) state_next = S_DECODE;
            S_DECODE: begin
                if (op == OP_HALT || op[3])
                    state_next = S_HALT;
                else
                    state_next = S_EXEC;
            end
            S_EXEC:   state_next = S_FETCH;
            S_HALT:   state_next = S_HALT;
            default:  state_next = S_IDLE;
        endcase
    end

    // Single-cycle strobes; reset suppresses every strobe in its own cycle.
    always_comb begin
        imem_req = 1'b0;
        pc_en    = 1'b0;
        pc_load  = 1'b0;
        we3      = 1'b0;
        wd_sel   = 1'b0;
        alu_sub  = 1'b0;
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    imem_req = 1'b1;
                    pc_en    = imem_ready;
                end
                S_EXEC: begin
                    case (op)
                        OP_SETN: begin
                            we3    = 1'b1;
                            wd_sel = 1'b1;
                        end
                        OP_ADD:  we3 = 1'b1;
                        OP_SUB: begin
                            we3     = 1'b1;
                            alu_sub = 1'b1;
                        end
                        OP_JUMPN: begin
                            pc_en   = 1'b1;
                            pc_load = 1'b1;
                        end
                        OP_JEQZN: begin
                            pc_en   = rd1_zero;
                            pc_load = rd1_zero;
                        end
                        OP_JNEZN: begin
                            pc_en   = !rd1_zero;
                            pc_load = !rd1_zero;
                        end
                        OP_NOP:  ;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    // State, IR capture, jump target (registered in DECODE) and sticky illegal flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            ir        <= '0;
            target_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            state <= state_next;
            if (state == S_FETCH && imem_ready)
                ir <= instr;
            if (state == S_DECODE) begin
                if (op[3])
                    illegal_q <= 1'b1;
                if (op == OP_JUMPN)
                    target_q <= PC_WIDTH'(ir[5:0]);
                else if (op == OP_JEQZN || op == OP_JNEZN)
                    target_q <= branch_target(pc, ir[3:0]);
            end
        end
    end

endmodule

// File: tb/tb_hmmm_controller.sv
// Testbench for hmmm_controller: drives instruction fetches and checks the
// EXEC-cycle strobes against expectations queued at fetch time.
module tb_hmmm_controller;

    logic       clk;
    logic       reset;
    logic       run;
    logic [9:0] instr;
    logic       imem_ready;
    logic [7:0] pc;
    logic       rd1_zero;
    logic       imem_req, pc_en, pc_load, we3, wd_sel, alu_sub, halted, illegal;
    logic [7:0] jump_target;
    logic [1:0] ra1, ra2, wa3;
    logic [3:0] imm;

    typedef struct packed {
        logic       we3;
        logic       wd_sel;
        logic       alu_sub;
        logic       pc_en;
        logic       pc_load;
        logic       chk_jt;
        logic [1:0] wa3;
        logic [1:0] ra1;
        logic [1:0] ra2;
        logic [3:0] imm;
        logic [7:0] jt;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    hmmm_controller #(.PC_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .run(run), .instr(instr),
        .imem_ready(imem_ready), .pc(pc), .rd1_zero(rd1_zero),
        .imem_req(imem_req), .pc_en(pc_en), .pc_load(pc_load),
        .jump_target(jump_target), .ra1(ra1), .ra2(ra2), .wa3(wa3),
        .we3(we3), .wd_sel(wd_sel), .imm(imm), .alu_sub(alu_sub),
        .halted(halted), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    function automatic exp_t mk(input logic w, input logic wd, input logic sub,
                                input logic pe, input logic pl, input logic cj,
                                input logic [1:0] wa, input logic [1:0] r1,
                                input logic [1:0] r2, input logic [3:0] im,
                                input logic [7:0] jt);
        exp_t e;
        e = {w, wd, sub, pe, pl, cj, wa, r1, r2, im, jt};
        return e;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},    imem_req, 0);
        check({tag, "_strobe"}, {pc_en, pc_load, we3, wd_sel, alu_sub}, 0);
        check({tag, "_flags"},  {halted, illegal}, 0);
        check({tag, "_jt"},     jump_target, 0);
    endtask

    // Runs FETCH (with wait cycles) and DECODE; queues the EXEC expectation.
    task automatic do_fetch(input logic [9:0] ins, input int waits,
                            input logic [7:0] pc_after, input bit has_exec, input exp_t e);
        for (int i = 0; i < waits; i++) begin
            imem_ready = 1'b0;
            instr      = 10'($urandom);
            mid();
            check("wait_req", imem_req, 1);
            check("wait_pcen", pc_en, 0);
            tick();
        end
        imem_ready = 1'b1;
        instr      = ins;
        if (has_exec) sb.push_back(e);
        mid();
        check("fetch_req", imem_req, 1);
        check("fetch_pcen", pc_en, 1);
        check("fetch_pcload", pc_load, 0);
        tick();
        imem_ready = 1'b0;
        instr      = 10'h3FF;
        pc         = pc_after;
        mid();
        check("dec_req", imem_req, 0);
        check("dec_strobes", {we3, pc_en}, 0);
        tick();
    endtask

    task automatic exec_check(input logic rz);
        exp_t e;
        rd1_zero = rz;
        mid();
        if (sb.size() == 0) begin
            check("sb_empty", 0, 1);
        end else begin
            e = sb.pop_front();
            check("ex_we3", we3, e.we3);
            check("ex_wdsel", wd_sel, e.wd_sel);
            check("ex_alusub", alu_sub, e.alu_sub);
            check("ex_pcen", pc_en, e.pc_en);
            check("ex_pcload", pc_load, e.pc_load);
            check("ex_wa3", wa3, e.wa3);
            check("ex_ra1", ra1, e.ra1);
            check("ex_ra2", ra2, e.ra2);
            check("ex_imm", imm, e.imm);
            check("ex_req", imem_req, 0);
            if (e.chk_jt) check("ex_jt", jump_target, e.jt);
        end
        tick();
    endtask

    task automatic start_run();
        run = 1'b1;
        mid();
        check("idle_req", imem_req, 0);
        tick();
        run = 1'b0;
    endtask

    initial begin
        exp_t none;
        none       = '0;
        reset      = 1'b1;
        run        = 1'b0;
        instr      = '0;
        imem_ready = 1'b0;
        pc         = '0;
        rd1_zero   = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mid();
            check("idle_wait_req", imem_req, 0);
            tick();
        end
        mid();
        check_reset_outputs("rst");
        tick();

        start_run();
        // SETN r1,5
        do_fetch(10'b0010_01_0101, 0, 8'h01, 1,
                 mk(1, 1, 0, 0, 0, 0, 2'd1, 2'd1, 2'd1, 4'd5, 8'h00));
        exec_check(1'b0);
        // SUB r3,r1,r2 with three wait cycles
        do_fetch(10'b0100_11_01_10, 3, 8'h02, 1,
                 mk(1, 0, 1, 0, 0, 0, 2'd3, 2'd1, 2'd2, 4'b0110, 8'h00));
        exec_check(1'b0);
        // JEQZN r2,-2 fetched at 0x00, taken
        do_fetch(10'b0110_10_1110, 0, 8'h01, 1,
                 mk(0, 0, 0, 1, 1, 1, 2'd2, 2'd2, 2'd2, 4'b1110, 8'hFE));
        exec_check(1'b1);
        // Same branch, not taken
        do_fetch(10'b0110_10_1110, 1, 8'h01, 1,
                 mk(0, 0, 0, 0, 0, 1, 2'd2, 2'd2, 2'd2, 4'b1110, 8'hFE));
        exec_check(1'b0);
        // JNEZN r0,+3 fetched at 0xFE: target wraps upward to 0x01
        do_fetch(10'b0111_00_0011, 0, 8'hFF, 1,
                 mk(0, 0, 0, 1, 1, 1, 2'd0, 2'd0, 2'd3, 4'b0011, 8'h01));
        exec_check(1'b0);
        // ADD r2,r3,r1
        do_fetch(10'b0011_10_11_01, 0, 8'h05, 1,
                 mk(1, 0, 0, 0, 0, 0, 2'd2, 2'd3, 2'd1, 4'b1101, 8'h00));
        exec_check(1'b1);
        // NOP
        do_fetch(10'b0000_00_0000, 0, 8'h06, 1,
                 mk(0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 4'd0, 8'h00));
        exec_check(1'b1);
        // JUMPN 0x2A
        do_fetch(10'b0101_101010, 0, 8'h07, 1,
                 mk(0, 0, 0, 1, 1, 1, 2'd2, 2'd2, 2'd2, 4'b1010, 8'h2A));
        exec_check(1'b0);
        // Illegal opcode 1010 -> HALT with illegal
        do_fetch(10'b1010_000000, 0, 8'h08, 0, none);
        run        = 1'b1;
        imem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mid();
            check("ill_halted", halted, 1);
            check("ill_flag", illegal, 1);
            check("ill_req", imem_req, 0);
            tick();
        end
        run        = 1'b0;
        imem_ready = 1'b0;
        reset      = 1'b1;
        tick();
        reset = 1'b0;
        mid();
        check_reset_outputs("rst_ill");
        tick();

        // HALT opcode: halted without illegal
        start_run();
        do_fetch(10'b0001_000000, 0, 8'h01, 0, none);
        mid();
        check("halt_halted", halted, 1);
        check("halt_illegal", illegal, 0);
        check("halt_req", imem_req, 0);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;

        // Reset during the EXEC cycle of an ADD
        start_run();
        do_fetch(10'b0011_01_10_11, 0, 8'h01, 0, none);
        reset = 1'b1;
        mid();
        check("rexec_we3", we3, 0);
        check("rexec_pcen", pc_en, 0);
        tick();
        reset = 1'b0;
        mid();
        check_reset_outputs("rst_exec");
        tick();
        mid();
        check("rst_exec_idle", imem_req, 0);
        tick();

        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
